// File: rtl/stopwatch_ctrl_if.sv
// Control bundle between the stopwatch sequencer and its neighbours.
// The button debouncers and the counter chain sit on the slave side.
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_lap;
  logic cnt_ovf;
  logic cnt_en;
  logic cnt_clr;
  logic disp_hold;
  logic running;
  logic ovf_led;

  modport master (
    input  btn_start, btn_lap, cnt_ovf,
    output cnt_en, cnt_clr, disp_hold, running, ovf_led
  );

  modport slave (
    output btn_start, btn_lap, cnt_ovf,
    input  cnt_en, cnt_clr, disp_hold, running, ovf_led
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edges to start/stop/lap/clear, prescaled count tick.
// Define SWCTRL_OVF_WRAP_EN to let the counter wrap on overflow instead of stopping.
module stopwatch_ctrl #(
  parameter int PRESCALE = 500000,
  parameter int PW       = 24
) (
  input logic              clk,
  input logic              clr,
  stopwatch_ctrl_if.master sw
);

`ifdef SWCTRL_OVF_WRAP_EN
  localparam bit OVF_STOPS = 1'b0;
`else
  localparam bit OVF_STOPS = 1'b1;
`endif

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, OVF} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;

  logic start_p0, start_p1, start_p2;
  logic lap_p0, lap_p1, lap_p2;
  logic start_edge, lap_edge;

  logic cnt_en_q, cnt_clr_q, disp_hold_q, running_q, ovf_led_q;
  logic cnt_en_nxt, cnt_clr_nxt, ovf_led_nxt;
  logic ovf_evt, tick_due, active, active_nxt;

  // p0/p1: two-flop synchronizer, p2: delay for rising-edge detect
  always_ff @(posedge clk) begin
    if (clr) begin
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
      lap_p0   <= 1'b0;
      lap_p1   <= 1'b0;
      lap_p2   <= 1'b0;
    end else begin
      start_p0 <= sw.btn_start;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
      lap_p0   <= sw.btn_lap;
      lap_p1   <= lap_p0;
      lap_p2   <= lap_p1;
    end
  end

  assign start_edge = start_p1 & ~start_p2;
  assign lap_edge   = lap_p1 & ~lap_p2;
  assign ovf_evt    = cnt_en_q & sw.cnt_ovf;
  assign tick_due   = (presc == LAST);
  assign active     = (state == RUN) || (state == LAP);
  assign active_nxt = (state_nxt == RUN) || (state_nxt == LAP);
  assign cnt_en_nxt = active & active_nxt & tick_due;

  // Overflow outranks a same-cycle button so a chain wrap is never lost.
  always_comb begin
    state_nxt   = state;
    cnt_clr_nxt = 1'b0;
    ovf_led_nxt = ovf_led_q;
    case (state)
      IDLE: begin
        if (start_edge) state_nxt = RUN;
      end
      RUN, LAP: begin
        if (ovf_evt) ovf_led_nxt = 1'b1;
        if (ovf_evt && OVF_STOPS) state_nxt = OVF;
        else if (start_edge)      state_nxt = PAUSE;
        else if (lap_edge)        state_nxt = (state == RUN) ? LAP : RUN;
      end
      PAUSE: begin
        if (start_edge) begin
          state_nxt = RUN;
        end else if (lap_edge) begin
          state_nxt   = IDLE;
          cnt_clr_nxt = 1'b1;
          ovf_led_nxt = 1'b0;
        end
      end
      OVF: begin
        if (lap_edge) begin
          state_nxt   = IDLE;
          cnt_clr_nxt = 1'b1;
          ovf_led_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pause keeps the partial tick, except a tick that was due is dropped.
  always_comb begin
    presc_nxt = presc;
    if (active_nxt) begin
      if (active) presc_nxt = tick_due ? '0 : presc + PW'(1);
    end else if (state_nxt == PAUSE) begin
      if (tick_due) presc_nxt = '0;
    end else begin
      presc_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      presc       <= '0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b1;
      disp_hold_q <= 1'b0;
      running_q   <= 1'b0;
      ovf_led_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      cnt_en_q    <= cnt_en_nxt;
      cnt_clr_q   <= cnt_clr_nxt;
      disp_hold_q <= (state_nxt == LAP);
      running_q   <= active_nxt;
      ovf_led_q   <= ovf_led_nxt;
    end
  end

  assign sw.cnt_en    = cnt_en_q;
  assign sw.cnt_clr   = cnt_clr_q;
  assign sw.disp_hold = disp_hold_q;
  assign sw.running   = running_q;
  assign sw.ovf_led   = ovf_led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random buttons/overflow,
// compared every cycle against a mode/phase reference model.
module tb_stopwatch_ctrl;
  localparam int P = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_OVF = 4;
`ifdef SWCTRL_OVF_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.PRESCALE(P), .PW(4)) dut (.clk(clk), .clr(clr), .sw(sw));

  int total = 0;
  int bad   = 0;
  int en_count = 0;

  // reference model
  int mode  = M_IDLE;
  int phase = 0;
  bit e_en = 0, e_clr = 1, e_hold = 0, e_run = 0, e_led = 0;
  bit qs[$];
  bit ql[$];

  function automatic bit rose(input int sel);
    int n;
    bit cur, prev;
    n = (sel == 0) ? qs.size() - 1 : ql.size() - 1;
    if (n < 2) return 1'b0;
    cur  = (sel == 0) ? qs[n-2] : ql[n-2];
    prev = (n < 3) ? 1'b0 : ((sel == 0) ? qs[n-3] : ql[n-3]);
    return cur && !prev;
  endfunction

  task automatic model_edge();
    bit rs, rl, was_act, is_act, ovf, clr_cmd;
    int nm;
    if (clr) begin
      mode = M_IDLE; phase = 0;
      e_en = 0; e_clr = 1; e_hold = 0; e_run = 0; e_led = 0;
      qs.delete(); ql.delete();
      return;
    end
    qs.push_back(sw.btn_start);
    ql.push_back(sw.btn_lap);
    if (qs.size() > 4) void'(qs.pop_front());
    if (ql.size() > 4) void'(ql.pop_front());
    rs = rose(0);
    rl = rose(1);
    was_act = (mode == M_RUN) || (mode == M_LAP);
    ovf = e_en && sw.cnt_ovf;
    nm = mode;
    clr_cmd = 0;
    if (mode == M_IDLE) begin
      if (rs) nm = M_RUN;
    end else if (was_act) begin
      if (ovf && !WRAP) nm = M_OVF;
      else if (rs)      nm = M_PAUSE;
      else if (rl)      nm = (mode == M_RUN) ? M_LAP : M_RUN;
    end else if (mode == M_PAUSE) begin
      if (rs) nm = M_RUN;
      else if (rl) begin nm = M_IDLE; clr_cmd = 1; end
    end else begin
      if (rl) begin nm = M_IDLE; clr_cmd = 1; end
    end
    if (ovf) e_led = 1;
    if (clr_cmd) e_led = 0;
    is_act = (nm == M_RUN) || (nm == M_LAP);
    e_en = was_act && is_act && (phase == P - 1);
    if (!is_act && nm != M_PAUSE) phase = 0;
    else if (was_act && (is_act || phase == P - 1)) phase = (phase + 1) % P;
    e_clr  = clr_cmd;
    e_hold = (nm == M_LAP);
    e_run  = is_act;
    mode   = nm;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (sw.cnt_en === 1'b1) en_count++;
    chk("cnt_en",    sw.cnt_en,    e_en);
    chk("cnt_clr",   sw.cnt_clr,   e_clr);
    chk("disp_hold", sw.disp_hold, e_hold);
    chk("running",   sw.running,   e_run);
    chk("ovf_led",   sw.ovf_led,   e_led);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // press for one sample, then wait until the press has been acted on
  task automatic press(input bit s, input bit l);
    sw.btn_start = s;
    sw.btn_lap   = l;
    step();
    sw.btn_start = 0;
    sw.btn_lap   = 0;
    steps(2);
  endtask

  initial begin
    bit found;
    sw.btn_start = 0;
    sw.btn_lap   = 0;
    sw.cnt_ovf   = 0;

    // reset
    clr = 1;
    steps(2);
    chk("rst_cnt_clr", sw.cnt_clr, 1'b1);
    chk("rst_running", sw.running, 1'b0);
    chk("rst_ovf_led", sw.ovf_led, 1'b0);
    clr = 0;
    en_count = 0;
    steps(50);
    chk("idle_cnt_clr", sw.cnt_clr, 1'b0);
    chk_int("idle_no_ticks", en_count, 0);

    // start: running appears two edges after the first sampled high
    sw.btn_start = 1;
    step();
    sw.btn_start = 0;
    step();
    chk("start_k1_running", sw.running, 1'b0);
    step();
    chk("start_k2_running", sw.running, 1'b1);
    en_count = 0;
    steps(40);
    chk_int("run_ticks_40", en_count, 10);

    // stop with prescaler at 2, resume, stop, lap-clear
    press(1, 0);
    chk("paused_running", sw.running, 1'b0);
    en_count = 0;
    steps(6);
    chk_int("pause_no_ticks", en_count, 0);
    press(1, 0);
    steps(7);
    press(1, 0);
    steps(3);
    press(0, 1);
    chk("lapclr_running", sw.running, 1'b0);
    steps(3);

    // lap freeze, unfreeze, simultaneous start+lap
    press(1, 0);
    steps(3);
    press(0, 1);
    chk("lap_hold", sw.disp_hold, 1'b1);
    en_count = 0;
    steps(12);
    chk_int("lap_ticks_12", en_count, 3);
    press(0, 1);
    chk("unlap_hold", sw.disp_hold, 1'b0);
    steps(5);
    press(1, 1);
    chk("both_paused", sw.running, 1'b0);
    press(0, 1);
    steps(2);

    // overflow coincident with a tick
    press(1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (e_en) found = 1;
    end
    chk("ovf_tick_seen", found, 1'b1);
    sw.cnt_ovf = 1;
    step();
    sw.cnt_ovf = 0;
    chk("ovf_led_set", sw.ovf_led, 1'b1);
    chk("ovf_running", sw.running, WRAP);
    steps(10);
    press(1, 0);
    steps(5);
    press(0, 1);
    steps(4);
    if (WRAP) begin
      press(1, 0);
      press(0, 1);
    end
    chk("ovf_led_cleared", sw.ovf_led, 1'b0);

    // clr while in LAP mid-prescale
    press(1, 0);
    press(0, 1);
    steps(2);
    clr = 1;
    step();
    chk("midclr_hold", sw.disp_hold, 1'b0);
    chk("midclr_cnt_clr", sw.cnt_clr, 1'b1);
    clr = 0;
    steps(3);

    // random buttons, overflow and occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) sw.btn_start = ~sw.btn_start;
      if ($urandom_range(0, 6) == 0) sw.btn_lap   = ~sw.btn_lap;
      sw.cnt_ovf = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 599) == 0);
      step();
    end
    clr = 0;
    sw.cnt_ovf = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
